// File: rtl/laserdrop_pack_fifo_if.sv
// laserdrop_pack_fifo_if: packed-write FIFO bus; master drives writes/reads/clear, slave returns data and status.
// Ports: clear, wr_en, wr_data, wr_words, rd_en (master->slave); wr_ready, rd_data, count, empty, full,
// almost_full, overflow, underflow (slave->master).
interface laserdrop_pack_fifo_if #(
  parameter int DW = 8,
  parameter int PACK = 2,
  parameter int DEPTH = 64
);
  logic                       clear;
  logic                       wr_en;
  logic [PACK*DW-1:0]         wr_data;
  logic [$clog2(PACK+1)-1:0]  wr_words;
  logic                       wr_ready;
  logic                       rd_en;
  logic [DW-1:0]              rd_data;
  logic [$clog2(DEPTH):0]     count;
  logic                       empty;
  logic                       full;
  logic                       almost_full;
  logic                       overflow;
  logic                       underflow;
  modport master (
    output clear, wr_en, wr_data, wr_words, rd_en,
    input  wr_ready, rd_data, count, empty, full, almost_full, overflow, underflow
  );
  modport slave (
    input  clear, wr_en, wr_data, wr_words, rd_en,
    output wr_ready, rd_data, count, empty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/laserdrop_pack_fifo.sv
// laserdrop_pack_fifo: FWFT FIFO accepting up to PACK words per cycle, popping one word per cycle.
// Ports: clock, reset_n (async active-low), bus (slave modport: write/read handshake, status, sticky flags).
module laserdrop_pack_fifo #(
  parameter int DW = 8,
  parameter int PACK = 2,
  parameter int DEPTH = 64,
  parameter int AFULL = DEPTH - PACK
) (
  input  logic                  clock,
  input  logic                  reset_n,
  laserdrop_pack_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(PACK + 1);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, space;
  logic          wr_ok, rd_ok, ovf, udf;
  assign space = CW'(DEPTH) - cnt;
  // Space is judged on the pre-edge count only; a same-cycle pop does not make room.
  assign wr_ok = bus.wr_en && bus.wr_words != '0 && bus.wr_words <= WW'(PACK) && CW'(bus.wr_words) <= space;
  assign rd_ok = bus.rd_en && cnt != '0;
  always_ff @(posedge clock) begin
    for (int k = 0; k < PACK; k++)
      if (reset_n && !bus.clear && wr_ok && k < int'(bus.wr_words))
        mem[wr_ptr + AW'(k)] <= bus.wr_data[k*DW +: DW];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(bus.wr_words);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (wr_ok ? CW'(bus.wr_words) : '0) - CW'(rd_ok);
      ovf <= ovf | (bus.wr_en & ~wr_ok);
      udf <= udf | (bus.rd_en & ~rd_ok);
    end
  end
  assign bus.rd_data     = (cnt == '0) ? '0 : mem[rd_ptr];
  assign bus.count       = cnt;
  assign bus.empty       = cnt == '0;
  assign bus.full        = cnt == CW'(DEPTH);
  assign bus.almost_full = cnt >= CW'(AFULL);
  assign bus.wr_ready    = space >= CW'(PACK);
  assign bus.overflow    = ovf;
  assign bus.underflow   = udf;
endmodule

// File: tb/tb_laserdrop_pack_fifo.sv
// tb_laserdrop_pack_fifo: directed and random checks of laserdrop_pack_fifo against a queue model.
module tb_laserdrop_pack_fifo;
  localparam int DW = 8, PACK = 2, DEPTH = 8, AFULL = 6;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;
  laserdrop_pack_fifo_if #(.DW(DW), .PACK(PACK), .DEPTH(DEPTH)) bus ();
  laserdrop_pack_fifo #(.DW(DW), .PACK(PACK), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":count"}, 32'(bus.count), 32'(n));
    chk({tag, ":rd_data"}, 32'(bus.rd_data), n > 0 ? 32'(q[0]) : 32'd0);
    chk({tag, ":empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ":full"}, 32'(bus.full), 32'(n == DEPTH));
    chk({tag, ":afull"}, 32'(bus.almost_full), 32'(n >= AFULL));
    chk({tag, ":wr_ready"}, 32'(bus.wr_ready), 32'(DEPTH - n >= PACK));
    chk({tag, ":overflow"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ":underflow"}, 32'(bus.underflow), 32'(m_udf));
  endtask
  task automatic step(input string tag, input logic we, input logic [PACK*DW-1:0] d,
                      input int words, input logic re, input logic clr);
    int n;
    logic wok;
    bus.wr_en = we;
    bus.wr_data = d;
    bus.wr_words = 2'(words);
    bus.rd_en = re;
    bus.clear = clr;
    @(posedge clock);
    n = q.size();
    wok = we && words >= 1 && words <= PACK && words <= DEPTH - n;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (we && !wok) m_ovf = 1'b1;
      if (re && n == 0) m_udf = 1'b1;
      if (re && n > 0) void'(q.pop_front());
      if (wok) for (int k = 0; k < words; k++) q.push_back(d[k*DW +: DW]);
    end
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clear = 1'b0;
    check_all(tag);
  endtask
  function automatic logic [PACK*DW-1:0] rnd();
    return (PACK*DW)'($urandom);
  endfunction
  task automatic fill(input string tag, input int n);
    while (n > 0) begin
      step(tag, 1'b1, rnd(), n >= 2 ? 2 : 1, 1'b0, 1'b0);
      n -= (n >= 2) ? 2 : 1;
    end
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.wr_words = '0;
    bus.rd_en = 1'b0;
    bus.clear = 1'b0;
    #12;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;
    step("w2", 1'b1, 16'hB2A1, 2, 1'b0, 1'b0);
    chk("w2_head", 32'(bus.rd_data), 32'hA1);
    step("pop1", 1'b0, '0, 0, 1'b1, 1'b0);
    chk("pop1_head", 32'(bus.rd_data), 32'hB2);
    step("clr", 1'b0, '0, 0, 1'b0, 1'b1);
    fill("fill8", 8);
    chk("full8", 32'(bus.full), 32'd1);
    step("ovf", 1'b1, rnd(), 2, 1'b0, 1'b0);
    step("clr", 1'b0, '0, 0, 1'b0, 1'b1);
    step("w1", 1'b1, rnd(), 1, 1'b0, 1'b0);
    step("w2b", 1'b1, rnd(), 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("pop3", 1'b0, '0, 0, 1'b1, 1'b0);
    step("udf", 1'b0, '0, 0, 1'b1, 1'b0);
    step("wz", 1'b1, rnd(), 0, 1'b0, 1'b0);
    step("clr", 1'b0, '0, 0, 1'b0, 1'b1);
    step("w3", 1'b1, rnd(), 3, 1'b0, 1'b0);
    step("clr", 1'b0, '0, 0, 1'b0, 1'b1);
    fill("fill7", 7);
    for (int i = 0; i < 6; i++) step("pop6", 1'b0, '0, 0, 1'b1, 1'b0);
    step("wrap", 1'b1, 16'h5A4B, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("wrap_pop", 1'b0, '0, 0, 1'b1, 1'b0);
    step("clr", 1'b0, '0, 0, 1'b0, 1'b1);
    fill("c7", 7);
    step("rw7", 1'b1, rnd(), 2, 1'b1, 1'b0);
    chk("rw7_count", 32'(bus.count), 32'd6);
    step("clr", 1'b0, '0, 0, 1'b0, 1'b1);
    fill("c5", 5);
    step("rw5", 1'b1, rnd(), 2, 1'b1, 1'b0);
    chk("rw5_count", 32'(bus.count), 32'd6);
    step("clr_wr", 1'b1, rnd(), 2, 1'b1, 1'b1);
    fill("c4", 4);
    #2;
    reset_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    check_all("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom), rnd(), int'($urandom_range(0, 3)), 1'($urandom),
           $urandom_range(0, 40) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/laserdrop_pack_fifo.md
LASERDROP_PACK_FIFO -- requirements
Module: laserdrop_pack_fifo

Interface
REQ-001 Parameter DW, default 8: width of one queue word (bits).
REQ-002 Parameter PACK, default 2: maximum words written per cycle; legal range 1 to 8.
REQ-003 Parameter DEPTH, default 64: capacity in words; power of two, at least 2*PACK.
REQ-004 Parameter AFULL, default DEPTH-PACK: almost_full threshold in words.
REQ-005 Port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous active-low reset.
REQ-007 Port clear, input, 1: synchronous flush.
REQ-008 Port wr_en, input, 1: write request.
REQ-009 Port wr_data, input, PACK*DW: packed words; word k occupies bits [k*DW +: DW]; word 0 is queued first.
REQ-010 Port wr_words, input, $clog2(PACK+1): number of valid words in wr_data, counted from word 0.
REQ-011 Port wr_ready, output, 1: high when free space (DEPTH-count) >= PACK.
REQ-012 Port rd_en, input, 1: pop the head word.
REQ-013 Port rd_data, output, DW: head word, first-word-fall-through; 0 when empty.
REQ-014 Port count, output, $clog2(DEPTH)+1: number of words currently held.
REQ-015 Port empty, output, 1: count == 0.
REQ-016 Port full, output, 1: count == DEPTH.
REQ-017 Port almost_full, output, 1: count >= AFULL.
REQ-018 Port overflow, output, 1: sticky flag, set by a rejected write.
REQ-019 Port underflow, output, 1: sticky flag, set by a read attempted while empty.

Function
REQ-020 Write acceptance: a write SHALL be accepted iff wr_en=1, 1 <= wr_words <= PACK, and wr_words <= DEPTH-count, where count is the pre-edge value; a read in the same cycle SHALL NOT credit space.
REQ-021 On an accepted write, words 0 to wr_words-1 SHALL be stored at wr_ptr, wr_ptr+1, and so on, modulo DEPTH; wr_ptr SHALL advance by wr_words.
REQ-022 If wr_en=1 and the write is not accepted (insufficient space, wr_words=0, or wr_words>PACK), no storage or pointer change SHALL occur and overflow SHALL be set to 1.
REQ-023 Read acceptance: a read SHALL be accepted iff rd_en=1 and empty=0; rd_ptr SHALL then advance by 1 modulo DEPTH.
REQ-024 If rd_en=1 while empty=1, no state change SHALL occur except that underflow SHALL be set to 1.
REQ-025 A simultaneous accepted read and write SHALL give count_next = count + wr_words - 1.
REQ-026 rd_data SHALL equal the storage word at rd_ptr combinationally, with zero latency from the edge that makes it the head.
REQ-027 A word written at edge N SHALL be visible on rd_data after edge N if the FIFO was empty before that edge (latency of 1 edge).
REQ-028 Pointers SHALL be $clog2(DEPTH) bits wide and wrap naturally; a packed write that spans the wrap SHALL split correctly across entries DEPTH-1 and 0.
REQ-029 count SHALL never exceed DEPTH nor go below 0 under any input sequence.
REQ-030 empty, full, almost_full and wr_ready SHALL be combinational decodes of registered count.
REQ-031 clear=1 SHALL, at the edge, zero count, wr_ptr, rd_ptr, overflow and underflow, overriding any concurrent read or write; storage contents need not be zeroed.
REQ-032 overflow and underflow SHALL hold their value until clear or reset.

Reset
REQ-033 reset_n=0 SHALL, asynchronously, force count=0, wr_ptr=0, rd_ptr=0, overflow=0 and underflow=0, which yields empty=1, full=0, almost_full=0, wr_ready=1 and rd_data=0.
REQ-034 Reset asserted in the middle of a write or read SHALL discard that operation; deassertion SHALL take effect at the next rising clock edge without glitching the outputs.
REQ-035 Storage arrays SHALL NOT require reset.

Verification (DW=8, PACK=2, DEPTH=8, AFULL=6)
REQ-036 Reset, then write {8'hB2,8'hA1} with wr_words=2 -> next cycle count=2, rd_data=8'hA1; pop -> rd_data=8'hB2, count=1.
REQ-037 Four 2-word writes -> count=8, full=1, wr_ready=0, almost_full=1; a fifth write -> overflow=1 and count stays 8.
REQ-038 Write 3 words via wr_words=1 then wr_words=2, pop 3 -> pop order matches write order; a further rd_en -> underflow=1, count=0.
REQ-039 Fill to 7, pop 6, then write 2 words -> words land in entries 7 and 0; subsequent pops return the original sequence across the wrap.
REQ-040 count=7 with simultaneous rd_en and 2-word write -> write rejected, overflow=1, count=6.
REQ-041 count=5 with simultaneous rd_en and 2-word write -> count=6; then clear with wr_en=1 -> count=0, empty=1, flags=0.
REQ-042 Assert reset_n=0 between clock edges while count=4 -> outputs immediately return to reset values.
